// File: rtl/bus_master_12_if.sv
// Requester-side handshake plus bus control strobes of the DataBus master.
// DataBus itself stays a plain inout port so the tristate resolves at the pins.
interface bus_master_12_if #(
  parameter int WIDTH = 12
) ();
  logic             start;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic             link_bus;
  logic             write;

  modport master (
    input  start,
    input  wdata,
    output busy,
    output done,
    output rdata,
    output err,
    output link_bus,
    output write
  );

  modport slave (
    output start,
    output wdata,
    input  busy,
    input  done,
    input  rdata,
    input  err,
    input  link_bus,
    input  write
  );
endinterface

// File: rtl/bus_master_12.sv
// DataBus initiator: drives an operand, strobes write, turns the bus around,
// then samples the responder's operand*3 result and flags any mismatch.
module bus_master_12 #(
  parameter int WIDTH        = 12,
  parameter int SETUP_CYCLES = 2,
  parameter int RD_WAIT      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_master_12_if.master      io,
  inout  wire [WIDTH-1:0]      DataBus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    STROBE,
    HOLD,
    TURN,
    READ,
    DONE
  } state_t;

  localparam logic [3:0] SETUP_INIT = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] READ_INIT  = 4'(RD_WAIT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             oe_q, oe_d;
  logic             link_q, link_d;
  logic             write_q, write_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    exp_d   = exp_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (io.start) begin
          op_d    = io.wdata;
          // x*3 as x + 2x keeps the product in WIDTH bits, dropping overflow
          exp_d   = io.wdata + {io.wdata[WIDTH-2:0], 1'b0};
          cnt_d   = SETUP_INIT;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = STROBE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      STROBE: state_d = HOLD;
      HOLD:   state_d = TURN;
      TURN: begin
        cnt_d   = READ_INIT;
        state_d = READ;
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          rdata_d = DataBus;
          err_d   = (DataBus != exp_q);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state so they come straight from flops
    oe_d    = (state_d == DRIVE) || (state_d == STROBE) || (state_d == HOLD);
    write_d = (state_d == STROBE);
    link_d  = (state_d == READ);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      exp_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      link_q  <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      oe_q    <= oe_d;
      link_q  <= link_d;
      write_q <= write_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign DataBus     = oe_q ? op_q : {WIDTH{1'bz}};
  assign io.busy     = busy_q;
  assign io.done     = done_q;
  assign io.rdata    = rdata_q;
  assign io.err      = err_q;
  assign io.link_bus = link_q;
  assign io.write    = write_q;

endmodule

// File: tb/tb_bus_master_12.sv
// Directed bench for bus_master_12: default build (A) and SETUP=1/RD_WAIT=3 build (B),
// each paired with a simple operand*3 responder on its own DataBus.
module tb_bus_master_12;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  int   viol;

  bus_master_12_if #(.WIDTH(12)) if_a ();
  bus_master_12_if #(.WIDTH(12)) if_b ();
  wire [11:0] bus_a;
  wire [11:0] bus_b;

  logic [11:0] resp_a;
  logic [11:0] resp_b;
  logic        force_a;
  logic [11:0] force_val;

  bus_master_12 #(.WIDTH(12), .SETUP_CYCLES(2), .RD_WAIT(2)) dut_a (
    .clk(clk), .rst(rst), .io(if_a.master), .DataBus(bus_a)
  );

  bus_master_12 #(.WIDTH(12), .SETUP_CYCLES(1), .RD_WAIT(3)) dut_b (
    .clk(clk), .rst(rst), .io(if_b.master), .DataBus(bus_b)
  );

  always #5 clk = ~clk;

  // Responders latch the operand on the rising write strobe, answer while link_bus is high
  always @(posedge if_a.write) resp_a = force_a ? force_val : bus_a * 12'd3;
  always @(posedge if_b.write) resp_b = bus_b * 12'd3;
  assign bus_a = if_a.link_bus ? resp_a : 12'hzzz;
  assign bus_b = if_b.link_bus ? resp_b : 12'hzzz;

  // Ownership monitor on bus A: 0 none, 1 master, 2 responder
  int prev_owner;
  int cur_owner;
  always @(negedge clk) begin
    if (dut_a.oe_q && if_a.link_bus) viol++;
    cur_owner = if_a.link_bus ? 2 : (dut_a.oe_q ? 1 : 0);
    if (prev_owner != 0 && cur_owner != 0 && prev_owner != cur_owner) viol++;
    prev_owner = cur_owner;
  end

  task automatic xfer(input bit sel_b, input logic [11:0] wd,
                      output int write_first, output int write_cnt,
                      output int link_first, output int link_cnt,
                      output int done_cyc, output int done_cnt,
                      output logic [11:0] rd, output logic er);
    write_first = -1; write_cnt = 0; link_first = -1; link_cnt = 0;
    done_cyc = -1; done_cnt = 0; rd = 12'h000; er = 1'b0;
    if (sel_b) begin if_b.wdata = wd; if_b.start = 1'b1; end
    else       begin if_a.wdata = wd; if_a.start = 1'b1; end
    @(posedge clk); #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (sel_b ? if_b.write : if_a.write) begin
        write_cnt++;
        if (write_first < 0) write_first = i;
      end
      if (sel_b ? if_b.link_bus : if_a.link_bus) begin
        link_cnt++;
        if (link_first < 0) link_first = i;
      end
      if (sel_b ? if_b.done : if_a.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = i;
        rd = sel_b ? if_b.rdata : if_a.rdata;
        er = sel_b ? if_b.err : if_a.err;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b exp=0", if_a.busy); end
    checks++; if (if_a.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got=%b exp=0", if_a.done); end
    checks++; if (if_a.rdata !== 12'h000) begin fails++; $display("[TB] FAIL reset_rdata got=%h exp=000", if_a.rdata); end
    checks++; if (if_a.err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got=%b exp=0", if_a.err); end
    checks++; if (if_a.link_bus !== 1'b0) begin fails++; $display("[TB] FAIL reset_link got=%b exp=0", if_a.link_bus); end
    checks++; if (if_a.write !== 1'b0) begin fails++; $display("[TB] FAIL reset_write got=%b exp=0", if_a.write); end
    checks++; if (dut_a.oe_q !== 1'b0) begin fails++; $display("[TB] FAIL reset_bus_release got=%b exp=0", dut_a.oe_q); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int wf, wc, lf, lc, dc, dn;
    logic [11:0] rd;
    logic er;
    xfer(1'b0, 12'h005, wf, wc, lf, lc, dc, dn, rd, er);
    checks++; if (wf !== 3) begin fails++; $display("[TB] FAIL basic_write_cycle got=%0d exp=3", wf); end
    checks++; if (wc !== 1) begin fails++; $display("[TB] FAIL basic_write_count got=%0d exp=1", wc); end
    checks++; if (lf !== 6) begin fails++; $display("[TB] FAIL basic_link_first got=%0d exp=6", lf); end
    checks++; if (lc !== 2) begin fails++; $display("[TB] FAIL basic_link_count got=%0d exp=2", lc); end
    checks++; if (dc !== 8) begin fails++; $display("[TB] FAIL basic_done_cycle got=%0d exp=8", dc); end
    checks++; if (dn !== 1) begin fails++; $display("[TB] FAIL basic_done_count got=%0d exp=1", dn); end
    checks++; if (rd !== 12'h00F) begin fails++; $display("[TB] FAIL basic_rdata got=%h exp=00f", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL basic_err got=%b exp=0", er); end
    checks++; if (if_a.rdata !== 12'h00F) begin fails++; $display("[TB] FAIL basic_rdata_hold got=%h exp=00f", if_a.rdata); end
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle_busy got=%b exp=0", if_a.busy); end
  endtask

  task automatic test_wrap;
    int wf, wc, lf, lc, dc, dn;
    logic [11:0] rd;
    logic er;
    xfer(1'b0, 12'hFFF, wf, wc, lf, lc, dc, dn, rd, er);
    checks++; if (rd !== 12'hFFD) begin fails++; $display("[TB] FAIL wrap_fff_rdata got=%h exp=ffd", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL wrap_fff_err got=%b exp=0", er); end
    xfer(1'b0, 12'h800, wf, wc, lf, lc, dc, dn, rd, er);
    checks++; if (rd !== 12'h800) begin fails++; $display("[TB] FAIL wrap_800_rdata got=%h exp=800", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL wrap_800_err got=%b exp=0", er); end
  endtask

  task automatic test_error;
    int wf, wc, lf, lc, dc, dn;
    logic [11:0] rd;
    logic er;
    force_a = 1'b1;
    force_val = 12'h123;
    xfer(1'b0, 12'h001, wf, wc, lf, lc, dc, dn, rd, er);
    force_a = 1'b0;
    checks++; if (rd !== 12'h123) begin fails++; $display("[TB] FAIL error_rdata got=%h exp=123", rd); end
    checks++; if (er !== 1'b1) begin fails++; $display("[TB] FAIL error_err got=%b exp=1", er); end
    checks++; if (dn !== 1) begin fails++; $display("[TB] FAIL error_done_count got=%0d exp=1", dn); end
    checks++; if (if_a.err !== 1'b1) begin fails++; $display("[TB] FAIL error_err_hold got=%b exp=1", if_a.err); end
  endtask

  task automatic test_back_to_back;
    int done_seen;
    int d1, d2;
    logic busy9;
    done_seen = 0; d1 = -1; d2 = -1; busy9 = 1'b1;
    viol = 0;
    if_a.wdata = 12'h010;
    if_a.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 9) busy9 = if_a.busy;
      if (if_a.done) begin
        done_seen++;
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    if_a.start = 1'b0;
    checks++; if (done_seen !== 2) begin fails++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", done_seen); end
    checks++; if (d1 !== 8) begin fails++; $display("[TB] FAIL b2b_first_done got=%0d exp=8", d1); end
    checks++; if (d2 !== 17) begin fails++; $display("[TB] FAIL b2b_second_done got=%0d exp=17", d2); end
    checks++; if (busy9 !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle_gap_busy got=%b exp=0", busy9); end
    checks++; if (if_a.rdata !== 12'h030) begin fails++; $display("[TB] FAIL b2b_rdata got=%h exp=030", if_a.rdata); end
    repeat (12) @(posedge clk);
    #1;
    checks++; if (viol !== 0) begin fails++; $display("[TB] FAIL b2b_bus_ownership got=%0d violations exp=0", viol); end
  endtask

  task automatic test_reset_abort;
    int wf, wc, lf, lc, dc, dn;
    logic [11:0] rd;
    logic er;
    int dn_after;
    bit seen;
    if_a.wdata = 12'h0A5;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (if_a.write) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL abort_reach_strobe got=timeout exp=write"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (if_a.write !== 1'b0) begin fails++; $display("[TB] FAIL abort_strobe_write got=%b exp=0", if_a.write); end
    checks++; if (dut_a.oe_q !== 1'b0) begin fails++; $display("[TB] FAIL abort_strobe_bus got=%b exp=0", dut_a.oe_q); end
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_strobe_busy got=%b exp=0", if_a.busy); end
    checks++; if (if_a.rdata !== 12'h000) begin fails++; $display("[TB] FAIL abort_strobe_rdata got=%h exp=000", if_a.rdata); end

    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (if_a.link_bus) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL abort_reach_read got=timeout exp=link_bus"); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (if_a.link_bus !== 1'b0) begin fails++; $display("[TB] FAIL abort_read_link got=%b exp=0", if_a.link_bus); end
    checks++; if (dut_a.oe_q !== 1'b0) begin fails++; $display("[TB] FAIL abort_read_bus got=%b exp=0", dut_a.oe_q); end
    checks++; if (if_a.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_read_busy got=%b exp=0", if_a.busy); end
    dn_after = 0;
    for (int i = 0; i < 10; i++) begin
      if (if_a.done) dn_after++;
      @(posedge clk); #1;
    end
    checks++; if (dn_after !== 0) begin fails++; $display("[TB] FAIL abort_no_done got=%0d exp=0", dn_after); end
    checks++; if (if_a.err !== 1'b0) begin fails++; $display("[TB] FAIL abort_err got=%b exp=0", if_a.err); end

    xfer(1'b0, 12'h002, wf, wc, lf, lc, dc, dn, rd, er);
    checks++; if (rd !== 12'h006) begin fails++; $display("[TB] FAIL abort_restart_rdata got=%h exp=006", rd); end
    checks++; if (dc !== 8) begin fails++; $display("[TB] FAIL abort_restart_done got=%0d exp=8", dc); end
  endtask

  task automatic test_param_b;
    int wf, wc, lf, lc, dc, dn;
    logic [11:0] rd;
    logic er;
    xfer(1'b1, 12'h100, wf, wc, lf, lc, dc, dn, rd, er);
    checks++; if (wf !== 2) begin fails++; $display("[TB] FAIL paramb_write_cycle got=%0d exp=2", wf); end
    checks++; if (lf !== 5) begin fails++; $display("[TB] FAIL paramb_link_first got=%0d exp=5", lf); end
    checks++; if (lc !== 3) begin fails++; $display("[TB] FAIL paramb_link_count got=%0d exp=3", lc); end
    checks++; if (dc !== 8) begin fails++; $display("[TB] FAIL paramb_done_cycle got=%0d exp=8", dc); end
    checks++; if (rd !== 12'h300) begin fails++; $display("[TB] FAIL paramb_rdata got=%h exp=300", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("[TB] FAIL paramb_err got=%b exp=0", er); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    fails = 0;
    viol = 0;
    prev_owner = 0;
    force_a = 1'b0;
    force_val = 12'h000;
    resp_a = 12'h000;
    resp_b = 12'h000;
    if_a.start = 1'b0;
    if_a.wdata = 12'h000;
    if_b.start = 1'b0;
    if_b.wdata = 12'h000;

    test_reset;
    test_basic;
    test_wrap;
    test_error;
    test_back_to_back;
    test_reset_abort;
    test_param_b;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
